imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default memory_pkg::MEM_ADDR_WIDTH, byte address width.
REQ-002 SHALL have parameter WORD_W, default memory_pkg::MEM_WORD_WIDTH, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 imem_req  output  1  read request to IMem.
REQ-008 imem_addr  output  ADDR_W  read byte address to IMem.
REQ-009 imem_data  input  WORD_W  IMem read data, valid the cycle after imem_req.
REQ-010 imem_addr_err  input  1  IMem address error, aligned with imem_data.
REQ-011 stall  input  1  downstream cannot accept an instruction this cycle.
REQ-012 redirect_valid  input  1  branch/jump redirect request.
REQ-013 redirect_addr  input  ADDR_W  redirect target.
REQ-014 instr_valid  output  1  instr/instr_pc valid.
REQ-015 instr  output  WORD_W  fetched instruction.
REQ-016 instr_pc  output  ADDR_W  address of instr.
REQ-017 fetch_err  output  1  sticky fetch fault flag.

Function
REQ-018 SHALL implement FSM states RUN, WAIT, HALT; reset enters RUN.
REQ-019 RUN: imem_req=1, imem_addr=pc; pc advances by 4 per accepted request; IMem latency exactly 1 cycle.
REQ-020 Response cycle: instr_valid=1, instr=imem_data, instr_pc=address requested the previous cycle.
REQ-021 Throughput: one instruction per cycle with stall=0, no bubbles after the first.
REQ-022 stall=1 with response arriving: capture it in a 1-entry skid buffer, deassert imem_req, go WAIT.
REQ-023 WAIT: instr/instr_pc/instr_valid held stable while stall=1; on stall=0 present buffer, resume RUN at buffered pc+4 next cycle.
REQ-024 redirect_valid=1 (any state, priority over stall): flush skid buffer and in-flight response; next cycle instr_valid=0, imem_req=1, imem_addr=redirect_addr; enter RUN.
REQ-025 imem_addr_err=1 on a response: instr_valid=0, fetch_err=1, imem_req=0, enter HALT.
REQ-026 HALT: imem_req=0, instr_valid=0; exits only via redirect (fetch_err cleared) or rst.
REQ-027 Redirect and imem_addr_err same cycle: redirect wins, error discarded.
REQ-028 pc SHALL wrap modulo 2^ADDR_W without flag.

Reset
REQ-029 rst SHALL set pc=RESET_PC, state RUN, skid buffer empty, instr_valid=0, instr=0, instr_pc=0, fetch_err=0, imem_req=0, imem_addr=0.
REQ-030 First imem_req=1 SHALL occur the cycle after rst deasserts, with imem_addr=RESET_PC.
REQ-031 rst mid-operation SHALL discard any in-flight response.

Configuration
REQ-032 Macro IMEM_FETCH_ALIGN_CHECK_EN: when defined, redirect_addr[1:0]!=0 sets fetch_err=1, enters HALT, issues no request.
REQ-033 When undefined, misaligned redirect addresses are passed to IMem unchanged; faults rely solely on imem_addr_err.

Verification
REQ-034 Reset, RESET_PC=0, stall=0 for 6 cycles -> imem_addr 0x0,0x4,...,0x14; instr_valid from cycle 2, instr_pc lagging imem_addr by one cycle.
REQ-035 stall=1 for 3 cycles during streaming at pc 0x8 -> instr/instr_pc (0x8) held, imem_req=0; after release, next instr_pc=0xC, no loss or duplication.
REQ-036 redirect_valid=1, redirect_addr=0x100 while stalled -> next cycle instr_valid=0, imem_addr=0x100; following instr_pc=0x100.
REQ-037 imem_addr_err=1 on response for 0x10000 -> fetch_err=1, imem_req=0 held; redirect to 0x0 clears fetch_err and resumes.
REQ-038 With IMEM_FETCH_ALIGN_CHECK_EN, redirect to 0x4001 -> fetch_err=1, no imem_req; without it, imem_addr=0x4001 issued.
REQ-039 rst asserted with outstanding request and stall=1 -> all outputs per REQ-029 next cycle, restart at RESET_PC.

Source files
------------

// File: rtl/memory_pkg.sv
// memory_pkg: shared memory geometry for the fetch path
package memory_pkg;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_WORD_WIDTH = 32;
endpackage

// File: rtl/imem_fetch.sv
// imem_fetch: 1-cycle-latency IMem fetcher with skid buffer, redirect and sticky fault; IMEM_FETCH_ALIGN_CHECK_EN faults misaligned redirects
module imem_fetch #(
  parameter int ADDR_W = memory_pkg::MEM_ADDR_WIDTH,
  parameter int WORD_W = memory_pkg::MEM_WORD_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              imem_addr_err,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_err
);
  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, resp_pc_q, resp_pc_d, buf_pc_q, buf_pc_d;
  logic [WORD_W-1:0] buf_instr_q, buf_instr_d;
  logic req_q, req_d, resp_q, resp_d, err_q, err_d, resp_ok, bad_redir;
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
  assign bad_redir = redirect_valid && |redirect_addr[1:0];
`else
  assign bad_redir = 1'b0;
`endif
  assign resp_ok     = resp_q && state_q == RUN && !imem_addr_err;
  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign fetch_err   = err_q;
  assign instr_valid = state_q == WAIT || resp_ok;
  assign instr       = state_q == WAIT ? buf_instr_q : resp_ok ? imem_data : '0;
  assign instr_pc    = state_q == WAIT ? buf_pc_q : resp_ok ? resp_pc_q : '0;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = 1'b0;
    addr_d      = addr_q;
    resp_d      = 1'b0;
    resp_pc_d   = addr_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    err_d       = err_q;
    if (redirect_valid) begin
      state_d = bad_redir ? HALT : RUN;
      err_d   = bad_redir;
      req_d   = !bad_redir;
      addr_d  = bad_redir ? addr_q : redirect_addr;
      pc_d    = redirect_addr + STEP;
    end else if (state_q == RUN) begin
      if (resp_q && imem_addr_err) begin
        state_d = HALT;
        err_d   = 1'b1;
      end else if (resp_q && stall) begin
        state_d     = WAIT;
        buf_pc_d    = resp_pc_q;
        buf_instr_d = imem_data;
      end else begin
        req_d  = 1'b1;
        addr_d = pc_q;
        pc_d   = pc_q + STEP;
        resp_d = req_q;
      end
    end else if (state_q == WAIT && !stall) begin
      state_d = RUN;
      req_d   = 1'b1;
      addr_d  = buf_pc_q + STEP;
      pc_d    = buf_pc_q + STEP + STEP;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      addr_q      <= '0;
      resp_q      <= 1'b0;
      resp_pc_q   <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      resp_q      <= resp_d;
      resp_pc_q   <= resp_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      err_q       <= err_d;
    end
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: table-driven cycle checks plus accept-order scoreboard for imem_fetch
module tb_imem_fetch;
  localparam logic [31:0] RESET_PC = 32'h0;
  typedef struct packed {
    logic r, s, v;
    logic [31:0] a;
    logic req;
    logic [31:0] addr;
    logic vld;
    logic [31:0] pc;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic rst, stall, redirect_valid, imem_req, imem_addr_err, instr_valid, fetch_err;
  logic [31:0] redirect_addr, imem_addr, imem_data, instr, instr_pc;
  int total = 0;
  int bad = 0;
  logic [31:0] sb_q[$];
  vec_t tq[$];
  imem_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_addr_err(imem_addr_err), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hDEAD_0000) + 32'h0000_0011;
  endfunction
  always @(posedge clk) begin
    imem_data     <= imem_req ? mem_word(imem_addr) : imem_data;
    imem_addr_err <= imem_req && imem_addr == 32'h0001_0000;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic sb_load(input logic [31:0] a);
    sb_q.delete();
    for (int i = 0; i < 16; i++) sb_q.push_back(a + 32'(4 * i));
  endtask
  task automatic drive(input logic r, input logic s, input logic v, input logic [31:0] a);
    logic [31:0] e;
    rst = r;
    stall = s;
    redirect_valid = v;
    redirect_addr = a;
    if (r) sb_load(RESET_PC);
    else if (v) sb_load(a);
    else if (instr_valid && !s) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got pc %h with nothing expected", instr_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr, mem_word(e));
      end
    end
  endtask
  task automatic add(input logic r, input logic s, input logic v, input logic [31:0] a,
                     input logic rq, input logic [31:0] ad, input logic vl, input logic [31:0] pc, input logic er);
    tq.push_back('{r, s, v, a, rq, ad, vl, pc, er});
  endtask
  task automatic chk_out(input string nm, input logic rq, input logic [31:0] ad, input logic vl,
                         input logic [31:0] pc, input logic er);
    chk({nm, "_req"}, 32'(imem_req), 32'(rq));
    chk({nm, "_addr"}, imem_addr, ad);
    chk({nm, "_valid"}, 32'(instr_valid), 32'(vl));
    chk({nm, "_pc"}, instr_pc, pc);
    chk({nm, "_instr"}, instr, vl ? mem_word(pc) : 32'h0);
    chk({nm, "_err"}, 32'(fetch_err), 32'(er));
  endtask
  initial begin
    vec_t t;
    add(0,0,0,0, 0,32'h0,0,32'h0,0);
    add(0,0,0,0, 1,32'h0,0,32'h0,0);
    add(0,0,0,0, 1,32'h4,1,32'h0,0);
    add(0,0,0,0, 1,32'h8,1,32'h4,0);
    add(0,0,0,0, 1,32'hC,1,32'h8,0);
    add(0,0,0,0, 1,32'h10,1,32'hC,0);
    add(0,0,0,0, 1,32'h14,1,32'h10,0);
    add(1,0,0,0, 1,32'h18,1,32'h14,0);
    add(0,0,0,0, 0,32'h0,0,32'h0,0);
    add(0,0,0,0, 1,32'h0,0,32'h0,0);
    add(0,0,0,0, 1,32'h4,1,32'h0,0);
    add(0,0,0,0, 1,32'h8,1,32'h4,0);
    add(0,1,0,0, 1,32'hC,1,32'h8,0);
    add(0,1,0,0, 0,32'hC,1,32'h8,0);
    add(0,1,0,0, 0,32'hC,1,32'h8,0);
    add(0,0,0,0, 0,32'hC,1,32'h8,0);
    add(0,0,0,0, 1,32'hC,0,32'h0,0);
    add(0,0,0,0, 1,32'h10,1,32'hC,0);
    add(0,1,0,0, 1,32'h14,1,32'h10,0);
    add(0,1,1,32'h100, 0,32'h14,1,32'h10,0);
    add(0,1,0,0, 1,32'h100,0,32'h0,0);
    add(0,0,0,0, 1,32'h104,1,32'h100,0);
    add(0,0,0,0, 1,32'h108,1,32'h104,0);
    add(0,0,1,32'h10000, 1,32'h10C,1,32'h108,0);
    add(0,0,0,0, 1,32'h10000,0,32'h0,0);
    add(0,0,0,0, 1,32'h10004,0,32'h0,0);
    add(0,0,0,0, 0,32'h10004,0,32'h0,1);
    add(0,0,1,32'h0, 0,32'h10004,0,32'h0,1);
    add(0,0,0,0, 1,32'h0,0,32'h0,0);
    add(0,0,1,32'h4001, 1,32'h4,1,32'h0,0);
`ifdef IMEM_FETCH_ALIGN_CHECK_EN
    add(0,0,0,0, 0,32'h4,0,32'h0,1);
    add(0,0,0,0, 0,32'h4,0,32'h0,1);
`else
    add(0,0,0,0, 1,32'h4001,0,32'h0,0);
    add(0,0,0,0, 1,32'h4005,1,32'h4001,0);
`endif
    drive(1, 0, 0, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < tq.size(); i++) begin
      t = tq[i];
      drive(t.r, t.s, t.v, t.a);
      chk_out($sformatf("row%0d", i), t.req, t.addr, t.vld, t.pc, t.err);
      @(negedge clk);
    end
    drive(0, 1, 0, 0);
    repeat (2) @(negedge clk);
    drive(1, 1, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, 0);
    chk_out("rst_stall", 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    chk_out("restart", 1, RESET_PC, 0, 32'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    chk_out("restart_resp", 1, RESET_PC + 32'h4, 1, RESET_PC, 0);
    @(negedge clk);
    drive(0, 0, 1, 32'hFFFF_FFF8);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0);
      chk($sformatf("wrap_addr%0d", k), imem_addr, 32'hFFFF_FFF8 + 32'(4 * k));
      if (k > 0) chk($sformatf("wrap_pc%0d", k), instr_pc, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
      @(negedge clk);
    end
    drive(0, 0, 1, 32'h0000_FFF8);
    @(negedge clk);
    drive(0, 0, 0, 0);
    chk_out("race0", 1, 32'hFFF8, 0, 32'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    chk_out("race1", 1, 32'hFFFC, 1, 32'hFFF8, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    chk_out("race2", 1, 32'h10000, 1, 32'hFFFC, 0);
    @(negedge clk);
    drive(0, 0, 1, 32'h200);
    chk("race3_errin", 32'(imem_addr_err), 32'h1);
    chk("race3_valid", 32'(instr_valid), 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    chk_out("race4", 1, 32'h200, 0, 32'h0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0);
    chk_out("race5", 1, 32'h204, 1, 32'h200, 0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
